// File: rtl/inta_sequencer_pkg.sv
// Shared definitions for the 8259A interrupt-acknowledge sequencer.
// Holds the FSM state encoding, default timing parameters, the INTA_n
// asserted level and a helper that sizes the shared phase down-counter.
package inta_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    P1,
    GAP,
    P2,
    VALID,
    RECOVER
  } state_t;

  localparam int PULSE_W_DEF   = 2;
  localparam int GAP_W_DEF     = 2;
  localparam int RECOVER_W_DEF = 4;

  // INTA_n is active low on the PIC side.
  localparam logic INTA_ASSERTED = 1'b0;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One counter times P1, GAP, P2 and RECOVER, so it must hold the longest load.
  function automatic int cnt_width(input int pulse_w, input int gap_w, input int recover_w);
    return $clog2(max3(pulse_w, gap_w, recover_w)) + 1;
  endfunction

endpackage

// File: rtl/inta_sequencer_if.sv
// Signal bundle between the CPU core / PIC pins and the INTA sequencer.
//   INT       PIC interrupt request (asynchronous to clk)
//   IE        core interrupt-enable flag
//   D         PIC data bus, carries the vector during the second INTA pulse
//   vec_ready core accepts the vector
//   INTA_n    acknowledge strobe to the PIC, active low
//   vec_valid captured vector available
//   vec       captured vector byte
//   busy      sequencer is not idle
// master: the sequencer itself.  slave: the surrounding PIC/core side.
interface inta_sequencer_if;
  logic       INT;
  logic       IE;
  logic [7:0] D;
  logic       vec_ready;
  logic       INTA_n;
  logic       vec_valid;
  logic [7:0] vec;
  logic       busy;

  modport master (
    input  INT, IE, D, vec_ready,
    output INTA_n, vec_valid, vec, busy
  );

  modport slave (
    output INT, IE, D, vec_ready,
    input  INTA_n, vec_valid, vec, busy
  );
endinterface

// File: rtl/inta_sequencer_sync_ff.sv
// Generic multi-flop synchroniser for a single asynchronous level.
// Used for the PIC INT line; suitable for other PIC-side async inputs.
//   clk    destination clock
//   reset  asynchronous, active-high; clears the whole chain to 0
//   i_d    asynchronous input level
//   o_q    synchronised level, STAGES clocks of latency
module inta_sequencer_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // NOTE: sequential state is written with <= so every flop in the chain
  // samples the value its neighbour held before this edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/inta_sequencer.sv
// CPU-side counterpart of the 8259A PIC.  Detects a synchronised INT while
// interrupts are enabled, drives the two-pulse active-low INTA_n sequence,
// captures the vector from D at the end of the second pulse and hands it to
// the core over a valid/ready handshake, then idles RECOVER_W cycles before
// looking at INT again.
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   bus    inta_sequencer_if.master (INT, IE, D, vec_ready in;
//          INTA_n, vec_valid, vec, busy out)
module inta_sequencer
  import inta_sequencer_pkg::*;
#(
  parameter int PULSE_W     = PULSE_W_DEF,
  parameter int GAP_W       = GAP_W_DEF,
  parameter int RECOVER_W   = RECOVER_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  inta_sequencer_if.master  bus
);

  localparam int CW = cnt_width(PULSE_W, GAP_W, RECOVER_W);

  // Counter loads are "cycles - 1": the phase ends on the edge that sees zero.
  localparam logic [CW-1:0] PULSE_LD   = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GAP_LD     = CW'(GAP_W - 1);
  localparam logic [CW-1:0] RECOVER_LD = CW'(RECOVER_W - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_inta_n;
  logic          r_vec_valid;
  logic [7:0]    r_vec;
  logic          r_busy;
  logic          w_int_sync;

  inta_sequencer_sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_int_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (bus.INT),
    .o_q   (w_int_sync)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the vector register is reset too, because vec is a visible
      // output that must read 8'h00 straight out of reset.
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_inta_n    <= ~INTA_ASSERTED;
      r_vec_valid <= 1'b0;
      r_vec       <= 8'h00;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // IE only matters here: once P1 starts the PIC needs both pulses.
          if (w_int_sync && bus.IE) begin
            r_state  <= P1;
            r_cnt    <= PULSE_LD;
            r_inta_n <= INTA_ASSERTED;
            r_busy   <= 1'b1;
          end
        end
        P1: begin
          if (r_cnt == '0) begin
            r_state  <= GAP;
            r_cnt    <= GAP_LD;
            r_inta_n <= ~INTA_ASSERTED;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        GAP: begin
          if (r_cnt == '0) begin
            r_state  <= P2;
            r_cnt    <= PULSE_LD;
            r_inta_n <= INTA_ASSERTED;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        P2: begin
          // D is still driven by the PIC on the edge that ends the pulse.
          if (r_cnt == '0) begin
            r_state     <= VALID;
            r_inta_n    <= ~INTA_ASSERTED;
            r_vec       <= bus.D;
            r_vec_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        VALID: begin
          if (r_vec_valid && bus.vec_ready) begin
            r_state     <= RECOVER;
            r_cnt       <= RECOVER_LD;
            r_vec_valid <= 1'b0;
          end
        end
        RECOVER: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_inta_n    <= ~INTA_ASSERTED;
          r_vec_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.INTA_n    = r_inta_n;
  assign bus.vec_valid = r_vec_valid;
  assign bus.vec       = r_vec;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_inta_sequencer.sv
// Self-checking bench for inta_sequencer.  A timeline model counts cycles
// since the start of an acknowledge sequence and derives INTA_n, vec_valid,
// vec and busy from that; directed scenarios add fixed-edge checks and a
// randomized phase exercises the rest, including asynchronous resets.
module tb_inta_sequencer;

  localparam int PW = 2;
  localparam int GW = 2;
  localparam int RW = 4;
  localparam int SS = 2;

  logic clk = 1'b0;
  logic reset;

  inta_sequencer_if bus ();

  inta_sequencer #(
    .PULSE_W     (PW),
    .GAP_W       (GW),
    .RECOVER_W   (RW),
    .SYNC_STAGES (SS)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_phase: 0 idle, 1 acknowledge in progress, 2 vector offered, 3 recovering.
  // m_t counts cycles since the sequence started (1 = first cycle of pulse 1).
  int         m_phase;
  int         m_t;
  int         m_rec;
  bit         m_valid;
  logic [7:0] m_vec;
  bit [SS-1:0] m_sync;

  function automatic void model_reset();
    m_phase = 0;
    m_t     = 0;
    m_rec   = 0;
    m_valid = 1'b0;
    m_vec   = 8'h00;
    m_sync  = '0;
  endfunction

  function automatic bit exp_inta_n();
    return !(m_phase == 1 && (m_t <= PW || m_t > PW + GW));
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit s;
    if (reset) begin
      model_reset();
      return;
    end
    s      = m_sync[SS-1];
    m_sync = {m_sync[SS-2:0], bus.INT};
    case (m_phase)
      0: if (s && bus.IE) begin m_phase = 1; m_t = 1; end
      1: begin
        if (m_t == 2 * PW + GW) begin
          m_vec   = bus.D;
          m_valid = 1'b1;
          m_phase = 2;
        end else begin
          m_t++;
        end
      end
      2: if (bus.vec_ready) begin m_valid = 1'b0; m_phase = 3; m_rec = RW; end
      3: begin m_rec--; if (m_rec == 0) m_phase = 0; end
      default: m_phase = 0;
    endcase
  endtask

  // ---------------- stepping helpers ----------------
  int   edge_n = 0;
  int   falls  = 0;
  logic prev_inta = 1'b1;

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    edge_n++;
    if (prev_inta === 1'b1 && bus.INTA_n === 1'b0) falls++;
    prev_inta = bus.INTA_n;
    check("inta_n",    bus.INTA_n,    exp_inta_n());
    check("vec_valid", bus.vec_valid, m_valid);
    check("vec",       bus.vec,       m_vec);
    check("busy",      bus.busy,      m_phase != 0);
  endtask

  task automatic run_to(input int k);
    while (edge_n < k) step();
  endtask

  // Mark the next edge as edge 0 of a scenario.
  task automatic mark_edge0();
    step();
    edge_n = 0;
  endtask

  task automatic reset_pulse(input string tag);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check({tag, "_rst_inta_n"},    bus.INTA_n,    1'b1);
    check({tag, "_rst_vec_valid"}, bus.vec_valid, 1'b0);
    check({tag, "_rst_busy"},      bus.busy,      1'b0);
    check({tag, "_rst_vec"},       bus.vec,       8'h00);
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.INT       = 1'b0;
    bus.IE        = 1'b0;
    bus.D         = 8'h00;
    bus.vec_ready = 1'b0;
    model_reset();

    // Reset state
    step();
    check("reset_inta_n",    bus.INTA_n,    1'b1);
    check("reset_vec_valid", bus.vec_valid, 1'b0);
    check("reset_vec",       bus.vec,       8'h00);
    check("reset_busy",      bus.busy,      1'b0);
    reset = 1'b0;
    repeat (3) step();

    // T1: basic sequence, ready already high
    bus.IE = 1'b1; bus.vec_ready = 1'b1; bus.D = 8'h0B;
    mark_edge0();
    bus.INT = 1'b1;
    run_to(2);  check("t1_pre_fall",  bus.INTA_n, 1'b1);
    run_to(3);  check("t1_p1_e3",     bus.INTA_n, 1'b0);
    run_to(4);  check("t1_p1_e4",     bus.INTA_n, 1'b0);
    run_to(5);  check("t1_gap_e5",    bus.INTA_n, 1'b1);
    run_to(7);  check("t1_p2_e7",     bus.INTA_n, 1'b0);
    run_to(8);  check("t1_p2_e8",     bus.INTA_n, 1'b0);
    run_to(9);
    check("t1_valid_e9",  bus.vec_valid, 1'b1);
    check("t1_vec_e9",    bus.vec,       8'h0B);
    check("t1_inta_e9",   bus.INTA_n,    1'b1);
    bus.INT = 1'b0;
    run_to(10); check("t1_valid_e10", bus.vec_valid, 1'b0);
    run_to(13); check("t1_busy_e13",  bus.busy,      1'b1);
    run_to(14); check("t1_busy_e14",  bus.busy,      1'b0);
    run_to(20);

    // T2: IE low blocks the request; raising IE starts it on the next edge
    bus.IE = 1'b0; bus.INT = 1'b1; bus.D = 8'h21;
    repeat (20) step();
    check("t2_ie0_inta_n", bus.INTA_n, 1'b1);
    check("t2_ie0_busy",   bus.busy,   1'b0);
    bus.IE = 1'b1;
    step();
    check("t2_ie1_fall", bus.INTA_n, 1'b0);
    bus.INT = 1'b0;
    repeat (15) step();
    check("t2_done_busy", bus.busy, 1'b0);

    // T3: INT and IE dropped during GAP, second pulse still issued
    bus.IE = 1'b1; bus.D = 8'h33;
    mark_edge0();
    bus.INT = 1'b1;
    run_to(5);
    bus.INT = 1'b0; bus.IE = 1'b0; bus.D = 8'h5A;
    run_to(7);  check("t3_p2_issued", bus.INTA_n, 1'b0);
    run_to(9);
    check("t3_valid", bus.vec_valid, 1'b1);
    check("t3_vec",   bus.vec,       8'h5A);
    run_to(20); check("t3_idle", bus.busy, 1'b0);

    // T4: core stalls vec_ready for 10 cycles
    bus.IE = 1'b1; bus.vec_ready = 1'b0; bus.D = 8'h0F;
    mark_edge0();
    bus.INT = 1'b1;
    run_to(9);
    check("t4_valid", bus.vec_valid, 1'b1);
    bus.D = 8'hEE;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t4_hold_vec",   bus.vec,       8'h0F);
      check("t4_hold_inta",  bus.INTA_n,    1'b1);
      check("t4_hold_valid", bus.vec_valid, 1'b1);
    end
    bus.vec_ready = 1'b1;
    step();
    check("t4_handoff_valid", bus.vec_valid, 1'b0);
    check("t4_handoff_busy",  bus.busy,      1'b1);
    check("t4_handoff_vec",   bus.vec,       8'h0F);
    bus.INT = 1'b0;
    repeat (10) step();
    check("t4_idle", bus.busy, 1'b0);

    // T5: INT held across two vectors
    bus.IE = 1'b1; bus.vec_ready = 1'b1; bus.D = 8'h08;
    mark_edge0();
    bus.INT = 1'b1;
    run_to(9);
    check("t5_vec1", bus.vec, 8'h08);
    bus.D = 8'h0A;
    run_to(14); check("t5_gap_inta", bus.INTA_n, 1'b1);
    check("t5_gap_busy", bus.busy, 1'b0);
    run_to(15); check("t5_second_fall", bus.INTA_n, 1'b0);
    run_to(21);
    check("t5_valid2", bus.vec_valid, 1'b1);
    check("t5_vec2",   bus.vec,       8'h0A);
    bus.INT = 1'b0;
    run_to(34);

    // T6: reset asserted during P2, fresh sequence afterwards
    bus.IE = 1'b1; bus.vec_ready = 1'b1; bus.D = 8'h77;
    mark_edge0();
    bus.INT = 1'b1;
    run_to(7);
    check("t6_in_p2", bus.INTA_n, 1'b0);
    reset_pulse("t6");
    edge_n = 0;
    falls  = 0;
    bus.D  = 8'h2C;
    run_to(2);  check("t6_pre_fall", bus.INTA_n, 1'b1);
    run_to(3);  check("t6_fall",     bus.INTA_n, 1'b0);
    run_to(9);
    check("t6_valid",  bus.vec_valid, 1'b1);
    check("t6_vec",    bus.vec,       8'h2C);
    check("t6_pulses", falls,         2);
    bus.INT = 1'b0;
    run_to(20);

    // Randomized traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 9) == 0) bus.INT = ~bus.INT;
      bus.IE        = ($urandom_range(0, 3) != 0);
      bus.D         = 8'($urandom);
      bus.vec_ready = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 199) == 0) reset_pulse("rnd");
      else step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
